bus_output_display: RTL and testbench

Output port of the 8-bit bus computer: loads a byte from the shared data bus on command, converts it to three BCD digits plus an optional sign, and drives a multiplexed 4-digit common-cathode 7-segment display. It is the consumer of bus values driven by the ALU and other bus sources. It only ever reads the bus and never drives it. Conversion is a sequential shift-add-3 (double-dabble) engine, and the display refresh uses a free-running scan counter.

---
 rtl/bus_output_display.sv | 192 +++++++++++++++++++
 tb/tb_bus_output_display.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_output_display.sv
// ---------------------------------------------------------------------------
// bus_output_display
//
// Output port of the 8-bit bus computer. On ld it captures a byte from the
// shared data bus. A sequential double-dabble engine then converts the byte
// to three BCD digits and a sign flag. The result drives a multiplexed
// 4-digit common-cathode 7-segment display.
//
// The bus is only ever read. This module never drives it, so from the bus's
// point of view this port is always high-Z.
//
// Parameters:
//   SCAN_DIV     clocks per digit slot (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ld           load strobe, samples bus and signed_mode
//   signed_mode  treat the loaded byte as two's complement
//   bus          shared 8-bit data bus (read only)
//   value        last loaded byte
//   busy         conversion in progress
//   seg          segments a..g on seg[0]..seg[6], active-high
//   dig          one-hot digit enable {sign, hundreds, tens, ones}
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank the leading zero digits (hundreds, tens)
// ---------------------------------------------------------------------------
module bus_output_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic       signed_mode,
    inout  wire  [7:0] bus,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] dig
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state, state_nx;
    logic [2:0]  step, step_nx;
    logic [7:0]  mag, mag_nx;
    logic [11:0] bcd, bcd_nx, bcd_adj;
    logic        negp, negp_nx;
    logic [7:0]  value_nx;
    logic        disp_wr;

    logic [3:0]  hund, tens, ones;
    logic        neg;
    logic [3:0]  hund_nx, tens_nx, ones_nx;
    logic        neg_nx;

    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic          adv;
    logic [6:0]    seg_nx;
    logic [3:0]    dig_nx;
    logic          blank_h, blank_t;

    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign busy    = (state == CONV);
    assign bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};

    // Conversion FSM. A load is accepted in any state and always restarts
    // the engine, so an in-flight result is simply abandoned.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        mag_nx   = mag;
        bcd_nx   = bcd;
        negp_nx  = negp;
        value_nx = value;
        disp_wr  = 1'b0;
        if (ld) begin
            value_nx = bus;
            negp_nx  = signed_mode & bus[7];
            // -0x80 wraps back to 0x80, which reads as magnitude 128.
            mag_nx   = (signed_mode & bus[7]) ? (8'd0 - bus) : bus;
            bcd_nx   = 12'd0;
            step_nx  = 3'd0;
            state_nx = CONV;
        end else if (state == CONV) begin
            {bcd_nx, mag_nx} = {bcd_adj, mag} << 1;
            step_nx = step + 3'd1;
            if (step == 3'd7) begin
                state_nx = IDLE;
                disp_wr  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 3'd0;
            mag   <= 8'd0;
            bcd   <= 12'd0;
            negp  <= 1'b0;
            value <= 8'd0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            mag   <= mag_nx;
            bcd   <= bcd_nx;
            negp  <= negp_nx;
            value <= value_nx;
        end
    end

    // Display registers only ever hold completed conversions.
    assign hund_nx = disp_wr ? bcd_nx[11:8] : hund;
    assign tens_nx = disp_wr ? bcd_nx[7:4]  : tens;
    assign ones_nx = disp_wr ? bcd_nx[3:0]  : ones;
    assign neg_nx  = disp_wr ? negp         : neg;

    assign adv    = (cnt == CW'(SCAN_DIV - 1));
    assign cnt_nx = adv ? '0 : cnt + 1'b1;
    assign idx_nx = adv ? idx + 2'd1 : idx;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (hund_nx == 4'd0);
    assign blank_t = (hund_nx == 4'd0) && (tens_nx == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    // seg/dig are computed from the next-cycle index and display contents.
    // They are registered every clock, but they only change when the index
    // advances or when the digit under the current index is rewritten.
    always_comb begin
        seg_nx = 7'h00;
        case (idx_nx)
            2'd0:    seg_nx = seg7(ones_nx);
            2'd1:    seg_nx = blank_t ? 7'h00 : seg7(tens_nx);
            2'd2:    seg_nx = blank_h ? 7'h00 : seg7(hund_nx);
            default: seg_nx = neg_nx ? 7'h40 : 7'h00;
        endcase
        dig_nx = 4'b0001 << idx_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hund <= 4'd0;
            tens <= 4'd0;
            ones <= 4'd0;
            neg  <= 1'b0;
            cnt  <= '0;
            idx  <= 2'd0;
            seg  <= 7'h3F;
            dig  <= 4'b0001;
        end else begin
            hund <= hund_nx;
            tens <= tens_nx;
            ones <= ones_nx;
            neg  <= neg_nx;
            cnt  <= cnt_nx;
            idx  <= idx_nx;
            seg  <= seg_nx;
            dig  <= dig_nx;
        end
    end

endmodule

// File: tb/tb_bus_output_display.sv
module tb_bus_output_display;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld = 1'b0;
    logic       sm = 1'b0;
    logic [7:0] bus_drv = 8'hA5;
    wire  [7:0] bus;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] dig;

    int checks = 0;
    int failures = 0;
    int bus_bad = 0;
    bit mon_en = 1'b0;
    bit saw200 = 1'b0;

    assign bus = bus_drv;

    always #5 clk = ~clk;

    bus_output_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ld), .signed_mode(sm), .bus(bus),
        .value(value), .busy(busy), .seg(seg), .dig(dig)
    );

    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [7:0] b;
        logic       s;
        int         h, t, o;
        logic       n;
    } vec_t;

    vec_t vecs [10];

    // Bus must always read what the bench drives (the DUT never contends).
    always @(negedge clk) begin
        if (bus !== bus_drv) bus_bad++;
        if (mon_en && dig == 4'b0100 && seg == 7'h5B) saw200 = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic ld_now(input logic [7:0] b, input logic s);
        bus_drv = b;
        sm = s;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        bus_drv = 8'hA5;
    endtask

    task automatic load(input logic [7:0] b, input logic s);
        @(negedge clk);
        ld_now(b, s);
    endtask

    // Called on the first negedge after the ld edge; counts busy cycles and
    // checks that value stays put while converting.
    task automatic busy_len(input string name, input logic [7:0] expv);
        int n = 0;
        int vbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            if (value !== expv) vbad++;
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_len"}, n, 8);
        chk({name, "_value_stable"}, vbad, 0);
    endtask

    task automatic scan(input string name, input int h, input int t, input int o, input logic n);
        logic [6:0] got [4];
        logic [6:0] exp [4];
        int bad_dig = 0;
        bit bh = 1'b0;
        bit bt = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = 'x;
        for (int i = 0; i < 4 * SD + 2; i++) begin
            @(negedge clk);
            case (dig)
                4'b0001: got[0] = seg;
                4'b0010: got[1] = seg;
                4'b0100: got[2] = seg;
                4'b1000: got[3] = seg;
                default: bad_dig++;
            endcase
        end
`ifdef LEADING_ZERO_BLANK_EN
        bh = (h == 0);
        bt = (h == 0) && (t == 0);
`endif
        exp[0] = lut[o];
        exp[1] = bt ? 7'h00 : lut[t];
        exp[2] = bh ? 7'h00 : lut[h];
        exp[3] = n ? 7'h40 : 7'h00;
        chk({name, "_dig_onehot"}, bad_dig, 0);
        chk({name, "_ones"}, got[0], exp[0]);
        chk({name, "_tens"}, got[1], exp[1]);
        chk({name, "_hund"}, got[2], exp[2]);
        chk({name, "_sign"}, got[3], exp[3]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{8'd173, 1'b0, 1, 7, 3, 1'b0};
        vecs[1] = '{8'h80,  1'b1, 1, 2, 8, 1'b1};
        vecs[2] = '{8'h7F,  1'b1, 1, 2, 7, 1'b0};
        vecs[3] = '{8'd5,   1'b0, 0, 0, 5, 1'b0};
        vecs[4] = '{8'hFF,  1'b0, 2, 5, 5, 1'b0};
        vecs[5] = '{8'hFF,  1'b1, 0, 0, 1, 1'b1};
        vecs[6] = '{8'h00,  1'b0, 0, 0, 0, 1'b0};
        vecs[7] = '{8'h80,  1'b0, 1, 2, 8, 1'b0};
        vecs[8] = '{8'h9C,  1'b1, 1, 0, 0, 1'b1};
        vecs[9] = '{8'd99,  1'b0, 0, 9, 9, 1'b0};

        // Reset state and scan start
        repeat (3) @(negedge clk);
        chk("rst_value", value, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dig", dig, 4'b0001);
        chk("rst_seg", seg, 7'h3F);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (dig == 4'b0010) break;
        end
        chk("rst_scan_adv", n, SD);

        // Table-driven conversions
        foreach (vecs[i]) begin
            load(vecs[i].b, vecs[i].s);
            chk($sformatf("v%0d_value", i), value, vecs[i].b);
            busy_len($sformatf("v%0d", i), vecs[i].b);
            scan($sformatf("v%0d", i), vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].n);
        end

        // Restart three cycles into a conversion: 200 must never appear
        load(8'd0, 1'b0);
        busy_len("pre0", 8'd0);
        mon_en = 1'b1;
        load(8'd200, 1'b0);
        repeat (2) @(negedge clk);
        ld_now(8'd42, 1'b0);
        busy_len("restart", 8'd42);
        scan("restart", 0, 4, 2, 1'b0);

        // ld coinciding with step 7: ld wins, no display write
        load(8'd0, 1'b0);
        busy_len("pre1", 8'd0);
        load(8'd200, 1'b0);
        repeat (7) @(negedge clk);
        chk("step7_busy_before", busy, 1'b1);
        ld_now(8'd42, 1'b0);
        busy_len("step7", 8'd42);
        scan("step7", 0, 4, 2, 1'b0);
        mon_en = 1'b0;
        chk("never_200", saw200, 1'b0);

        // Reset asserted mid-conversion
        load(8'd173, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_value", value, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_dig", dig, 4'b0001);
        chk("midrst_seg", seg, 7'h3F);
        chk("midrst_bus", bus, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        scan("midrst", 0, 0, 0, 1'b0);
        chk("midrst_value_after", value, 8'h00);

        chk("bus_integrity", bus_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
